// File: rtl/xalu_serial.sv
// Digit-serial ALU: operands latched once, SLICE bits processed per clock LSB first, valid/ready on both sides.
// Optional accumulator operand is built only when XALU_ACC_EN is defined.
module xalu_serial #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci_right,
    input  logic             ci_left,
    input  logic             com,
    input  logic             use_acc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             co_left,
    output logic             co_right,
    output logic             ovf,
    output logic             equ,
    output logic             zero,
    output logic             neg_zero,
    output logic             busy
);
    localparam int N     = WIDTH / SLICE;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    localparam logic [2:0] OP_ADD = 3'd0, OP_AND = 3'd1, OP_OR  = 3'd2, OP_XOR = 3'd3,
                           OP_PSA = 3'd4, OP_PSB = 3'd5, OP_SHR = 3'd6, OP_SHL = 3'd7;

    if (WIDTH % SLICE != 0) begin : g_bad_width
        $error("xalu_serial: WIDTH must be an integer multiple of SLICE");
    end

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_carry;
    logic [WIDTH-1:0] r_res;
    logic [2:0]       r_op;
    logic [WIDTH-1:0] r_a, r_b;
    logic             r_cir, r_cil, r_com;
    logic             r_co_left, r_co_right, r_ovf, r_equ, r_zero, r_negz;

    logic [WIDTH-1:0] w_b_eff, w_shl, w_shr, w_res_next;
    logic [SLICE-1:0] w_raw, w_dig;
    logic [SLICE:0]   w_sum;
    logic             w_cout, w_hs;
    int               w_base;

    // One digit of the selected function; bit SLICE carries the ADD carry-out.
    function automatic logic [SLICE:0] digit_eval(input logic [2:0] f,
                                                  input logic [SLICE-1:0] ad, bd, ld, rd,
                                                  input logic cin);
        logic [SLICE:0] s;
        s = {1'b0, ad} + {1'b0, bd} + {{SLICE{1'b0}}, cin};
        case (f)
            OP_ADD:  return s;
            OP_AND:  return {1'b0, ad & bd};
            OP_OR:   return {1'b0, ad | bd};
            OP_XOR:  return {1'b0, ad ^ bd};
            OP_PSA:  return {1'b0, ad};
            OP_PSB:  return {1'b0, bd};
            OP_SHR:  return {1'b0, rd};
            default: return {1'b0, ld};
        endcase
    endfunction

    function automatic logic add_ovf(input logic signed [WIDTH-1:0] x, y, input logic sgn);
        return ((x < 0) == (y < 0)) && (sgn != (x < 0));
    endfunction

`ifdef XALU_ACC_EN
    logic [WIDTH-1:0] r_acc;
    always_ff @(posedge clk) begin
        if (!rst_n)     r_acc <= '0;
        else if (w_hs)  r_acc <= r_res;
    end
    assign w_b_eff = use_acc ? r_acc : b;
`else
    assign w_b_eff = b | {WIDTH{use_acc & 1'b0}};
`endif

    assign w_shl  = {r_a[WIDTH-2:0], r_cir};
    assign w_shr  = {r_cil, r_a[WIDTH-1:1]};
    assign w_base = int'(r_cnt) * SLICE;
    assign w_sum  = digit_eval(r_op, r_a[w_base +: SLICE], r_b[w_base +: SLICE],
                               w_shl[w_base +: SLICE], w_shr[w_base +: SLICE], r_carry);
    assign w_raw  = w_sum[SLICE-1:0];
    assign w_cout = w_sum[SLICE];
    assign w_dig  = r_com ? ~w_raw : w_raw;
    assign w_hs   = (r_state == S_DONE) && out_ready;

    always_comb begin
        w_res_next = r_res;
        w_res_next[w_base +: SLICE] = w_dig;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_carry    <= 1'b0;
            r_res      <= '0;
            r_co_left  <= 1'b0;
            r_co_right <= 1'b0;
            r_ovf      <= 1'b0;
            r_equ      <= 1'b0;
            r_zero     <= 1'b0;
            r_negz     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (in_valid) begin
                    r_op    <= op;
                    r_a     <= a;
                    r_b     <= w_b_eff;
                    r_cir   <= ci_right;
                    r_cil   <= ci_left;
                    r_com   <= com;
                    r_carry <= ci_right;
                    r_cnt   <= '0;
                    r_state <= S_RUN;
                end
                S_RUN: begin
                    r_res   <= w_res_next;
                    r_carry <= w_cout;
                    if (r_cnt == LAST) begin
                        // Final digit: capture status from the completed result.
                        r_cnt      <= '0;
                        r_co_left  <= (r_op == OP_ADD) ? w_cout :
                                      (r_op == OP_SHL) ? r_a[WIDTH-1] : 1'b0;
                        r_co_right <= (r_op == OP_SHR) && r_a[0];
                        r_ovf      <= (r_op == OP_ADD) && add_ovf($signed(r_a), $signed(r_b), w_raw[SLICE-1]);
                        r_equ      <= (r_a == r_b);
                        r_zero     <= (w_res_next == '0);
                        r_negz     <= &w_res_next;
                        r_state    <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE: if (out_ready) r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign busy      = (r_state == S_RUN);
    assign out_valid = (r_state == S_DONE);
    assign result    = r_res;
    assign co_left   = out_valid & r_co_left;
    assign co_right  = out_valid & r_co_right;
    assign ovf       = out_valid & r_ovf;
    assign equ       = out_valid & r_equ;
    assign zero      = out_valid & r_zero;
    assign neg_zero  = out_valid & r_negz;
endmodule

// File: tb/tb_xalu_serial.sv
// Directed bench for xalu_serial at WIDTH=16, SLICE=4 with hand-computed expectations.
module tb_xalu_serial;
    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_ready, ci_right, ci_left, com, use_acc;
    logic        out_valid, out_ready, co_left, co_right, ovf, equ, zero, neg_zero, busy;
    logic [2:0]  op;
    logic [15:0] a, b, result;
    int          checks = 0;
    int          errors = 0;
    int          lat;

    xalu_serial #(.WIDTH(16), .SLICE(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .a(a), .b(b), .ci_right(ci_right), .ci_left(ci_left), .com(com), .use_acc(use_acc),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .co_left(co_left),
        .co_right(co_right), .ovf(ovf), .equ(equ), .zero(zero), .neg_zero(neg_zero), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Flags packed as {co_left, co_right, ovf, equ, zero, neg_zero}.
    task automatic chk_flags(input string tag, input logic [5:0] exp);
        chk(tag, {26'd0, co_left, co_right, ovf, equ, zero, neg_zero}, {26'd0, exp});
    endtask

    task automatic issue(input logic [2:0] f, input logic [15:0] va, input logic [15:0] vb,
                         input logic cr, input logic cl, input logic cm, input logic ua);
        op = f; a = va; b = vb; ci_right = cr; ci_left = cl; com = cm; use_acc = ua;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        a = ~va; b = vb ^ 16'h5A5A; ci_right = ~cr; ci_left = ~cl; com = ~cm; op = ~f; use_acc = 1'b0;
        chk("accept_busy", {31'd0, busy}, 32'd1);
    endtask

    task automatic wait_done(output int k);
        k = 0;
        while (!out_valid && k < 40) begin
            step();
            k++;
        end
        if (!out_valid) k = -1;
    endtask

    task automatic run_op(input string tag, input logic [2:0] f, input logic [15:0] va,
                          input logic [15:0] vb, input logic cr, input logic cl, input logic cm,
                          input logic ua, input logic [15:0] exp_res);
        issue(f, va, vb, cr, cl, cm, ua);
        wait_done(lat);
        chk({tag, "_latency"}, lat, 32'd4);
        chk({tag, "_result"}, {16'd0, result}, {16'd0, exp_res});
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("hs_out_valid", {31'd0, out_valid}, 32'd0);
        chk("hs_in_ready", {31'd0, in_ready}, 32'd1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op = 3'd0; a = '0; b = '0;
        ci_right = 1'b0; ci_left = 1'b0; com = 1'b0; use_acc = 1'b0;
        do_reset();
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_result", {16'd0, result}, 32'd0);
        chk_flags("rst_flags", 6'b000000);

        run_op("add_ovf", 3'd0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0, 16'h8000);
        chk_flags("add_ovf_flags", 6'b001000);
        handshake();

        run_op("add_cin", 3'd0, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        chk_flags("add_cin_flags", 6'b100010);
        handshake();

        run_op("add_com", 3'd0, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 16'hFFFF);
        chk_flags("add_com_flags", 6'b100001);
        handshake();

        run_op("shl", 3'd7, 16'h8001, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0003);
        chk_flags("shl_flags", 6'b100000);
        handshake();

        run_op("shr", 3'd6, 16'h8001, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h4000);
        chk_flags("shr_flags", 6'b010000);
        handshake();

        run_op("xor_eq", 3'd3, 16'h1234, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        chk_flags("xor_eq_flags", 6'b000110);
        handshake();

        // Backpressure: result held while a competing request waits.
        run_op("bp", 3'd2, 16'h00F0, 16'h0F00, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0FF0);
        op = 3'd4; a = 16'hABCD; b = 16'h0000; ci_right = 1'b0; ci_left = 1'b0; com = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_hold_result", {16'd0, result}, 32'h0FF0);
            chk("bp_hold_in_ready", {31'd0, in_ready}, 32'd0);
            chk_flags("bp_hold_flags", 6'b000000);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("bp_release_valid", {31'd0, out_valid}, 32'd0);
        chk("bp_release_busy", {31'd0, busy}, 32'd0);
        chk("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        a = 16'h1111;
        chk("bp_next_accept", {31'd0, busy}, 32'd1);
        wait_done(lat);
        chk("bp_next_latency", lat, 32'd4);
        chk("bp_next_result", {16'd0, result}, 32'hABCD);
        handshake();

        // Abort in the second RUN cycle.
        issue(3'd0, 16'h1234, 16'h1111, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
        chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk_flags("abort_flags", 6'b000000);
        run_op("and_after", 3'd1, 16'hF0F0, 16'hFF00, 1'b0, 1'b0, 1'b0, 1'b0, 16'hF000);
        chk_flags("and_after_flags", 6'b000000);
        handshake();

`ifdef XALU_ACC_EN
        do_reset();
        run_op("acc_load", 3'd0, 16'h0005, 16'h0003, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0008);
        handshake();
        run_op("acc_use", 3'd0, 16'h0002, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b1, 16'h000A);
        handshake();
        do_reset();
        run_op("acc_rst", 3'd0, 16'h0001, 16'h7777, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0001);
        handshake();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/xalu_serial.md
Name: xalu_serial

Overview:
- Parametrised, registered successor to the 4-bit combinational ALU slice. Operands are WIDTH bits wide.
- Operands are latched once, then processed SLICE bits per clock, LSB digit first, with the carry held in a register between digits.
- Uses the same 3-bit function encoding, complement-output mode, carry-in/out and zero/equality status as the slice. Adds a valid/ready handshake on both sides, a signed-overflow flag and an optional accumulator operand.
- Sits between the operand-fetch logic and the result bus of the wider datapath.

Parameters:
- WIDTH, 16: operand/result width in bits. Must be an integer multiple of SLICE; elaboration fails otherwise.
- SLICE, 4: bits processed per clock. N = WIDTH/SLICE digit cycles per operation.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- in_valid  in  1  operation request
- in_ready  out  1  block can accept a request
- op  in  3  function: 0 ADD, 1 AND, 2 OR, 3 XOR, 4 PASSA, 5 PASSB, 6 SHR, 7 SHL
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- ci_right  in  1  carry-in for ADD; shift-in for SHL
- ci_left  in  1  shift-in for SHR
- com  in  1  complement result
- use_acc  in  1  use accumulator as B (effective only with XALU_ACC_EN)
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- result  out  WIDTH  result, complemented when com=1
- co_left  out  1  ADD carry-out of MSB, or SHL bit shifted out (a[WIDTH-1])
- co_right  out  1  SHR bit shifted out (a[0])
- ovf  out  1  ADD signed overflow: operand sign bits equal and result sign differs (computed before COM)
- equ  out  1  latched A == latched effective B
- zero  out  1  result == 0 (after COM)
- neg_zero  out  1  result all ones (after COM)
- busy  out  1  state is RUN

Behaviour:
- FSM states: IDLE, RUN, DONE.
- Reset (rst_n=0 at a clk edge): state=IDLE; digit counter=0; carry register=0; result register=0. All flags and out_valid read 0; in_ready=1 after reset.
- IDLE:
  - in_ready=1.
  - When in_valid=1, latch op, a, effective b, ci_right, ci_left and com; carry register=ci_right; digit index=0; go to RUN.
- RUN:
  - in_ready=0, busy=1.
  - Each clock, compute digit i (bits i*SLICE .. i*SLICE+SLICE-1) and write it into the result register.
  - ADD: ripple across the digit from the carry register, then update the carry register with the digit carry-out.
  - Logic and PASS ops: bitwise on the digit.
  - SHR: bit j takes a[j+1]; the MSB takes ci_left.
  - SHL: bit j takes a[j-1]; bit 0 takes ci_right.
  - After the digit with index N-1, go to DONE.
- Latency: out_valid rises exactly N clocks after the accepting edge (4 at defaults).
- DONE:
  - out_valid=1; result and all flags stay stable until out_ready=1.
  - On the edge where out_valid and out_ready are both 1: go to IDLE.
  - A new request is not accepted in that same cycle; in_ready is 0 in DONE.
- Flags: registered and valid only while out_valid=1; forced to 0 otherwise.
  - co_left: nonzero only for ADD/SHL.
  - co_right: nonzero only for SHR.
  - ovf: nonzero only for ADD.
  - equ is independent of op.
- Input handling: input ports are ignored outside IDLE; changing a or b mid-operation must not affect the result.
- rst_n=0 during RUN or DONE aborts the operation: the block returns to the reset state, out_valid=0 on the next cycle, and no result is produced.
- N=1 (SLICE=WIDTH) is legal: one RUN cycle.

Optional Feature:
- Macro: XALU_ACC_EN.
- When defined:
  - The block holds a WIDTH-bit accumulator, loaded with the (post-COM) result on every DONE handshake; reset value 0.
  - When a request is accepted with use_acc=1, the accumulator is used as effective B instead of b.
  - equ compares A with that effective B.
- When not defined: no accumulator is built, use_acc is ignored, and effective B is always b.

Test Plan:
- Signed-overflow add: WIDTH=16, SLICE=4; ADD a=0x7FFF, b=0x0001, ci_right=0 -> out_valid exactly 4 clocks after accept; result=0x8000, ovf=1, co_left=0, zero=0.
- Carry-in and complement: ADD a=0xFFFF, b=0x0000, ci_right=1 -> result=0x0000, co_left=1, zero=1, ovf=0. Repeat with com=1 -> result=0xFFFF, neg_zero=1, zero=0.
- Shifts: SHL a=0x8001, ci_right=1 -> result=0x0003, co_left=1. SHR a=0x8001, ci_left=0 -> result=0x4000, co_right=1. XOR a=b=0x1234 -> result=0, equ=1, zero=1.
- Backpressure: hold out_ready=0 for 10 clocks in DONE -> result and flags stable, in_ready=0, and a second in_valid is not accepted. Then out_ready=1 for one cycle -> IDLE; the next request is accepted the following cycle.
- Reset mid-operation: assert rst_n=0 on the 2nd RUN cycle -> next cycle out_valid=0, in_ready=1, busy=0, flags 0. A fresh AND a=0xF0F0, b=0xFF00 -> 0xF000.
- XALU_ACC_EN: ADD 0x0005+0x0003 -> 0x0008. Next, ADD a=0x0002 with use_acc=1 -> 0x000A. After reset, use_acc=1 with a=0x0001 -> 0x0001.
